// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined MIPS datapath.
// Port A: full-word ALU writeback. Port B: byte-lane load return.
// Per-register pending bits track loads in flight for the hazard unit.
// Register 0 reads as zero and ignores writes and marks; dbg_v0 mirrors $v0.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wea,
    input  logic [ADDR_W-1:0]     waa,
    input  logic [DATA_W-1:0]     wda,
    input  logic [DATA_W/8-1:0]   web,
    input  logic [ADDR_W-1:0]     wab,
    input  logic [DATA_W-1:0]     wdb,
    input  logic                  mark_en,
    input  logic [ADDR_W-1:0]     mark_addr,
    output logic                  any_busy,
    output logic [DATA_W-1:0]     dbg_v0
);

    localparam int NLANE = DATA_W / 8;
    // With only two registers there is no $v0; the tap then shows r0 (zero).
    localparam int V0    = (DEPTH > 2) ? 2 : 0;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DATA_W-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W-1:0] ra_cur;
    logic [7:0]        lane;

    // Next register contents and pending bits: port B owns its enabled lanes,
    // port A fills the rest; a mark beats a same-cycle load return.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            mem_next[r]  = mem[r];
            pend_next[r] = pend[r];
            if (r != 0) begin
                for (int j = 0; j < NLANE; j++) begin
                    if (web[j] && (wab == ADDR_W'(r)))
                        mem_next[r][8*j +: 8] = wdb[8*j +: 8];
                    else if (wea && (waa == ADDR_W'(r)))
                        mem_next[r][8*j +: 8] = wda[8*j +: 8];
                end
                if (mark_en && (mark_addr == ADDR_W'(r)))
                    pend_next[r] = 1'b1;
                else if ((|web) && (wab == ADDR_W'(r)))
                    pend_next[r] = 1'b0;
            end
        end
    end

    // Storage, scoreboard and debug tap; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++)
                mem[r] <= '0;
            pend   <= '0;
            dbg_v0 <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++)
                mem[r] <= mem_next[r];
            pend   <= pend_next;
            dbg_v0 <= mem_next[V0];
        end
    end

    // Read ports with optional per-lane forwarding; forced to zero in reset
    // so forwarded write data cannot leak out while the array is cleared.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        ra_cur  = '0;
        lane    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra_cur = ra[i*ADDR_W +: ADDR_W];
            if (reset && (ra_cur != '0)) begin
                for (int j = 0; j < NLANE; j++) begin
                    lane = mem[ra_cur][8*j +: 8];
                    if ((BYPASS != 0) && web[j] && (wab == ra_cur))
                        lane = wdb[8*j +: 8];
                    else if ((BYPASS != 0) && wea && (waa == ra_cur))
                        lane = wda[8*j +: 8];
                    rd[i*DATA_W + 8*j +: 8] = lane;
                end
                // A full-word load return this cycle satisfies the consumer now.
                rd_busy[i] = pend[ra_cur] &&
                             !((BYPASS != 0) && (&web) && (wab == ra_cur));
            end
        end
    end

    assign any_busy = |pend;

endmodule
